fifo_push_arbiter: RTL and testbench

- Shares the write (push) side of one synchronous FIFO among N requesters.
- Each requester presents data with a valid/ready handshake. Requesters are served round-robin, with an optional bounded burst for the current owner.
- Drives the FIFO's push/din and honours its full flag. The FIFO pop side is untouched and belongs to the consumer.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_push_arbiter_rr_pick.sv | 42 ++++
 rtl/fifo_push_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_push_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO push arbiter.
package fifo_arb_pkg;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index type for the default requester count.
    localparam int ARB_N = 4;
    typedef logic [clog2(ARB_N)-1:0] idx_t;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate valid so that 'start' sits at
// bit 0, take the lowest set bit, then map the offset back to an index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] rot;
    int           off;
    int           pos;

    // Rotate, priority-encode, unrotate.
    always_comb begin
        rot   = '0;
        any   = 1'b0;
        off   = 0;
        pos   = 0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            rot[k] = valid[pos];
        end
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !any) begin
                any = 1'b1;
                off = k;
            end
        end
        pos = int'(start) + off;
        if (pos >= N) pos = pos - N;
        idx = IW'(pos);
        if (any) grant[pos] = 1'b1;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N requesters, with an
// optional bounded burst for the current owner.
// Build option: define FIFO_ARB_STATS_EN to add per-requester grant counters.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 2,
    parameter int MAX_BURST = 1,
    localparam int IW       = clog2(N),
    localparam int BW       = clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      io_req_valid,
    input  logic [N*W-1:0]    io_req_data,
    output logic [N-1:0]      io_req_ready,
    input  logic              io_fifo_full,
    output logic              io_fifo_push,
    output logic [W-1:0]      io_fifo_din,
    output logic [IW-1:0]     io_grant_idx,
    input  logic [IW-1:0]     io_stat_sel,
    output logic [STAT_W-1:0] io_stat_count
);

    logic [IW-1:0] last_ptr;
    logic [BW-1:0] burst_cnt;

    logic [IW-1:0] scan_start;
    logic [N-1:0]  pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          owner_cont;
    logic          grant_any;
    logic [IW-1:0] gidx;

    // Scan always begins just past the last owner; owner continuation
    // overrides the scan result while its burst has budget left.
    always_comb begin
        scan_start = (int'(last_ptr) == N - 1) ? '0 : last_ptr + 1'b1;
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .valid (io_req_valid),
        .start (scan_start),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant decision and FIFO-side outputs; burst_cnt = 0 means no owner.
    always_comb begin
        owner_cont   = io_req_valid[last_ptr] && (burst_cnt != '0) &&
                       (burst_cnt < BW'(MAX_BURST));
        grant_any    = !reset && !io_fifo_full && (owner_cont || pick_any);
        gidx         = owner_cont ? last_ptr : pick_idx;
        io_req_ready = '0;
        io_fifo_din  = '0;
        io_grant_idx = '0;
        if (grant_any) begin
            io_req_ready[gidx] = 1'b1;
            io_fifo_din        = io_req_data[int'(gidx)*W +: W];
            io_grant_idx       = gidx;
        end
        io_fifo_push = grant_any;
    end

    // Owner and burst tracking; a grant not continuing the burst starts a new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ptr  <= IW'(N - 1);
            burst_cnt <= '0;
        end else if (grant_any) begin
            if (owner_cont) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                last_ptr  <= gidx;
                burst_cnt <= BW'(1);
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [N];

    // Saturating per-requester handshake counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (io_req_ready[i] && io_req_valid[i] && stat_cnt[i] != STAT_MAX)
                    stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
    end

    // Selected counter readout, forced to zero during reset.
    always_comb begin
        io_stat_count = '0;
        if (!reset && int'(io_stat_sel) < N) io_stat_count = stat_cnt[io_stat_sel];
    end
`else
    logic unused_stat_sel;

    // Counters not built; select input intentionally ignored.
    always_comb begin
        unused_stat_sel = ^io_stat_sel;
        io_stat_count   = '0;
    end
`endif

    // Picker one-hot is equivalent to the index form used above.
    logic unused_pick_grant;
    assign unused_pick_grant = ^pick_grant;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with MAX_BURST=1 and MAX_BURST=3 instances.
module tb_fifo_push_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  valid;
    logic [7:0]  data;
    logic        full;
    logic [1:0]  sel;

    logic [3:0]  rdy1, rdy3;
    logic        push1, push3;
    logic [1:0]  din1, din3;
    logic [1:0]  idx1, idx3;
    logic [15:0] stat1, stat3;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string      tag;
        int         dut;
        logic [3:0] ready;
        logic       push;
        logic [1:0] din;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fifo_push_arbiter #(.N(4), .W(2), .MAX_BURST(1)) u_b1 (
        .clk(clk), .reset(reset), .io_req_valid(valid), .io_req_data(data),
        .io_req_ready(rdy1), .io_fifo_full(full), .io_fifo_push(push1),
        .io_fifo_din(din1), .io_grant_idx(idx1), .io_stat_sel(sel),
        .io_stat_count(stat1)
    );

    fifo_push_arbiter #(.N(4), .W(2), .MAX_BURST(3)) u_b3 (
        .clk(clk), .reset(reset), .io_req_valid(valid), .io_req_data(data),
        .io_req_ready(rdy3), .io_fifo_full(full), .io_fifo_push(push3),
        .io_fifo_din(din3), .io_grant_idx(idx3), .io_stat_sel(sel),
        .io_stat_count(stat3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reset for one cycle with the given valid pattern, checking outputs held quiet.
    task automatic do_reset(input logic [3:0] v);
        @(negedge clk);
        reset = 1'b1; valid = v; full = 1'b0; data = 8'($urandom);
        #1;
        chk("rst_ready1", rdy1, 0);  chk("rst_push1", push1, 0);
        chk("rst_din1", din1, 0);    chk("rst_idx1", idx1, 0);
        chk("rst_stat1", stat1, 0);
        chk("rst_ready3", rdy3, 0);  chk("rst_push3", push3, 0);
        chk("rst_din3", din3, 0);    chk("rst_stat3", stat3, 0);
        @(negedge clk);
        reset = 1'b0; valid = 4'b0000;
    endtask

    // One cycle: drive, queue expectations (g<0 = no grant), compare, then
    // optionally check the MAX_BURST=3 burst counter after the edge.
    task automatic step(input string tag, input logic [1:0] duts, input logic [3:0] v,
                        input logic f, input int g, input int c);
        exp_t e;
        @(negedge clk);
        valid = v; full = f; data = 8'($urandom);
        for (int d = 0; d < 2; d++) begin
            if (duts[d]) begin
                e.tag   = tag;
                e.dut   = d;
                e.push  = (g >= 0);
                e.ready = (g >= 0) ? 4'(1 << g) : 4'b0;
                e.idx   = (g >= 0) ? 2'(g) : 2'b0;
                e.din   = (g >= 0) ? data[g*2 +: 2] : 2'b0;
                sb.push_back(e);
            end
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                chk({e.tag, "_ready1"}, rdy1, e.ready);
                chk({e.tag, "_push1"}, push1, e.push);
                chk({e.tag, "_din1"}, din1, e.din);
                chk({e.tag, "_idx1"}, idx1, e.idx);
            end else begin
                chk({e.tag, "_ready3"}, rdy3, e.ready);
                chk({e.tag, "_push3"}, push3, e.push);
                chk({e.tag, "_din3"}, din3, e.din);
                chk({e.tag, "_idx3"}, idx3, e.idx);
            end
        end
        @(posedge clk);
        #1;
        if (c >= 0) chk({tag, "_cnt"}, 32'(u_b3.burst_cnt), c);
    endtask

    initial begin
        int rr_seq[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
        int b3_seq[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        int b3_cnt[9]  = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
        int solo_cnt[5] = '{1, 2, 3, 1, 2};
        reset = 1'b1; valid = '0; data = '0; full = 1'b0; sel = '0;
        repeat (2) @(posedge clk);

        do_reset(4'b1111);

        for (int i = 0; i < 8; i++) step($sformatf("rr%0d", i), 2'b01, 4'b1111, 1'b0, rr_seq[i], -1);
        for (int i = 0; i < 3; i++) step($sformatf("full%0d", i), 2'b01, 4'b1010, 1'b1, -1, -1);
        step("after_full0", 2'b01, 4'b1010, 1'b0, 1, -1);
        step("after_full1", 2'b01, 4'b1010, 1'b0, 3, -1);

        @(negedge clk);
        valid = 4'b0000; sel = 2'd1;
        #1;
`ifdef FIFO_ARB_STATS_EN
        chk("stat_sel1_rr", stat1, 3);
`else
        chk("stat_sel1_rr", stat1, 0);
`endif

        do_reset(4'b0011);
        for (int i = 0; i < 9; i++) step($sformatf("burst%0d", i), 2'b10, 4'b0011, 1'b0, b3_seq[i], b3_cnt[i]);

        do_reset(4'b0100);
        for (int i = 0; i < 5; i++) step($sformatf("solo%0d", i), 2'b10, 4'b0100, 1'b0, 2, solo_cnt[i]);

        do_reset(4'b0000);
        step("mid0", 2'b10, 4'b0010, 1'b0, 1, 1);
        step("mid1", 2'b10, 4'b0010, 1'b0, 1, 2);
        do_reset(4'b1111);
        step("post_rst", 2'b11, 4'b1111, 1'b0, 0, 1);

`ifdef FIFO_ARB_STATS_EN
        do_reset(4'b0000);
        @(negedge clk);
        valid = 4'b0001;
        repeat (70000) @(negedge clk);
        valid = 4'b0000; sel = 2'd0;
        #1;
        chk("stat_sat_sel0", stat1, 16'hFFFF);
        sel = 2'd1;
        #1;
        chk("stat_sat_sel1", stat1, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
